// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low hex patterns (g..a), blank and scan-receiver states.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  // Encoder-side mapping from nibble to active-low pattern.
  function automatic logic [SEG_W-1:0] seg7_encode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] pat;
    case (nib)
      4'h0: pat = SEG_HEX_0;
      4'h1: pat = SEG_HEX_1;
      4'h2: pat = SEG_HEX_2;
      4'h3: pat = SEG_HEX_3;
      4'h4: pat = SEG_HEX_4;
      4'h5: pat = SEG_HEX_5;
      4'h6: pat = SEG_HEX_6;
      4'h7: pat = SEG_HEX_7;
      4'h8: pat = SEG_HEX_8;
      4'h9: pat = SEG_HEX_9;
      4'hA: pat = SEG_HEX_A;
      4'hB: pat = SEG_HEX_B;
      4'hC: pat = SEG_HEX_C;
      4'hD: pat = SEG_HEX_D;
      4'hE: pat = SEG_HEX_E;
      default: pat = SEG_HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational decode of an active-low segment pattern to {hit, blank, nibble}.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic             hit_c,
  output logic             blank_c,
  output logic [NIB_W-1:0] nibble_c
);

  always_comb begin
    hit_c    = 1'b1;
    blank_c  = 1'b0;
    nibble_c = '0;
    case (pat_i)
      SEG_HEX_0: nibble_c = 4'h0;
      SEG_HEX_1: nibble_c = 4'h1;
      SEG_HEX_2: nibble_c = 4'h2;
      SEG_HEX_3: nibble_c = 4'h3;
      SEG_HEX_4: nibble_c = 4'h4;
      SEG_HEX_5: nibble_c = 4'h5;
      SEG_HEX_6: nibble_c = 4'h6;
      SEG_HEX_7: nibble_c = 4'h7;
      SEG_HEX_8: nibble_c = 4'h8;
      SEG_HEX_9: nibble_c = 4'h9;
      SEG_HEX_A: nibble_c = 4'hA;
      SEG_HEX_B: nibble_c = 4'hB;
      SEG_HEX_C: nibble_c = 4'hC;
      SEG_HEX_D: nibble_c = 4'hD;
      SEG_HEX_E: nibble_c = 4'hE;
      SEG_HEX_F: nibble_c = 4'hF;
      SEG_BLANK: begin
        hit_c   = 1'b0;
        blank_c = 1'b1;
      end
      default:   hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Scanned seven-segment bus receiver: settles each digit slot, decodes and holds one nibble per digit.
// Optional decimal-point capture is enabled with `define SEG7_SCAN_RX_DP_EN.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    frame_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_done
`ifdef SEG7_SCAN_RX_DP_EN
  ,
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp
`endif
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    fd_q, fd_d;
  logic                    chg_c;
  logic                    cap_c;
  logic                    dec_hit_c;
  logic                    dec_blank_c;
  logic [NIB_W-1:0]        dec_nib_c;

`ifdef SEG7_SCAN_RX_DP_EN
  logic                    dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  assign chg_c = (seg_n != seg_q) || (an_n != an_q) || (dp_n != dpn_q);
  assign dp    = dp_q;
`else
  assign chg_c = (seg_n != seg_q) || (an_n != an_q);
`endif

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign frame_done = fd_q;

  seg7_pattern_dec u_dec (
    .pat_i    (seg_q),
    .hit_c    (dec_hit_c),
    .blank_c  (dec_blank_c),
    .nibble_c (dec_nib_c)
  );

  // State, input stage and captured slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      seg_q    <= '1;
      an_q     <= '1;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      fd_q     <= 1'b0;
`ifdef SEG7_SCAN_RX_DP_EN
      dpn_q    <= 1'b1;
      dp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      fd_q     <= fd_d;
`ifdef SEG7_SCAN_RX_DP_EN
      dpn_q    <= dpn_d;
      dp_q     <= dp_d;
`endif
    end
  end

  // Next-state: settle counting, capture into the selected slot, frame tracking.
  always_comb begin
    seg_d    = seg_n;
    an_d     = an_n;
    state_d  = state_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    fd_d     = 1'b0;
`ifdef SEG7_SCAN_RX_DP_EN
    dpn_d    = dp_n;
    dp_d     = dp_q;
`endif
    cap_c = (state_q == ST_SETTLE) && (cnt_q == CNT_LAST);

    if (chg_c) begin
      cnt_d   = '0;
      state_d = $onehot(~an_n) ? ST_SETTLE : ST_IDLE;
    end else if (state_q == ST_SETTLE) begin
      if (cap_c) state_d = ST_HELD;
      else       cnt_d   = cnt_q + CNT_W'(1);
    end

    if (cap_c) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_q[i]) begin
          digits_d[4*i +: 4] = dec_hit_c ? dec_nib_c : 4'h0;
          valid_d[i]         = dec_hit_c;
          err_d[i]           = !dec_hit_c && !dec_blank_c;
          seen_d[i]          = 1'b1;
`ifdef SEG7_SCAN_RX_DP_EN
          dp_d[i]            = ~dpn_q;
`endif
        end
      end
    end

    // A clear on the same edge as the completing capture wins over the pulse.
    if (frame_clr) begin
      seen_d = '0;
    end else if (&seen_d) begin
      fd_d   = 1'b1;
      seen_d = '0;
    end
  end

endmodule
